// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: one-hot T-state ring (T1..T6), opcode decode into
// the 12-bit control word, run/hold gating and a terminal HALT state.
// All state changes on the falling edge so the control word is settled for the
// whole low-to-high half and datapath registers capture on the rising edge.
module sap1_controller (
    input  logic        clk,
    input  logic        res,
    input  logic        run,
    input  logic [3:0]  opcode,
    output logic [5:0]  t,
    output logic [11:0] con,
    output logic        hlt
);

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    // One-hot T-states, t[5]=T1 .. t[0]=T6
    localparam logic [5:0] T1 = 6'b100000;
    localparam logic [5:0] T2 = 6'b010000;
    localparam logic [5:0] T3 = 6'b001000;
    localparam logic [5:0] T4 = 6'b000100;
    localparam logic [5:0] T5 = 6'b000010;
    localparam logic [5:0] T6 = 6'b000001;

    // Control word bit positions {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo}
    localparam int CP = 11;
    localparam int EP = 10;
    localparam int LM = 9;
    localparam int CE = 8;
    localparam int LI = 7;
    localparam int EI = 6;
    localparam int LA = 5;
    localparam int EA = 4;
    localparam int SU = 3;
    localparam int EU = 2;
    localparam int LB = 1;
    localparam int LO = 0;

    logic [0:0] state_reg;
    logic [0:0] state_next;
    logic [5:0] t_reg;
    logic [5:0] t_next;
    logic [5:0] t_shift;

    // Ring successor of the current T-state: shift right, T6 wraps to T1
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_ring
            if (gi == 5) begin : g_wrap
                assign t_shift[gi] = t_reg[0];
            end else begin : g_shift
                assign t_shift[gi] = t_reg[gi+1];
            end
        end
    endgenerate

    // Next-state selection: reset beats everything, HALT is sticky, run=0 holds
    always_comb begin
        state_next = state_reg;
        t_next     = t_reg;
        if (res) begin
            state_next = ST_RUN;
            t_next     = T1;
        end else if (state_reg == ST_HALT) begin
            state_next = ST_HALT;
            t_next     = 6'b000000;
        end else if (run) begin
            if (t_reg == T4 && opcode == OP_HLT) begin
                state_next = ST_HALT;
                t_next     = 6'b000000;
            end else begin
                t_next = t_shift;
            end
        end
    end

    // State register, updated on the falling edge
    always_ff @(negedge clk) begin
        state_reg <= state_next;
        t_reg     <= t_next;
    end

    // Control word decode of (T-state, opcode), forced to zero on hold or halt
    always_comb begin
        con = 12'h000;
        if (run && state_reg == ST_RUN) begin
            case (t_reg)
                T1: begin
                    con[EP] = 1'b1;
                    con[LM] = 1'b1;
                end
                T2: con[CP] = 1'b1;
                T3: begin
                    con[CE] = 1'b1;
                    con[LI] = 1'b1;
                end
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            con[EI] = 1'b1;
                            con[LM] = 1'b1;
                        end
                        OP_OUT: begin
                            con[EA] = 1'b1;
                            con[LO] = 1'b1;
                        end
                        default: con = 12'h000;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LDA: begin
                            con[CE] = 1'b1;
                            con[LA] = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            con[CE] = 1'b1;
                            con[LB] = 1'b1;
                        end
                        default: con = 12'h000;
                    endcase
                end
                T6: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        con[EU] = 1'b1;
                        con[LA] = 1'b1;
                        con[SU] = (opcode == OP_SUB);
                    end
                end
                default: con = 12'h000;
            endcase
        end
    end

    assign t   = t_reg;
    assign hlt = (state_reg == ST_HALT);

endmodule

// File: tb/tb_sap1_controller.sv
// Scoreboard bench for sap1_controller. Stimulus drives inputs just after each
// falling edge and queues the outputs expected for that cycle; a monitor pops
// and compares on the rising edge. Bus-driver exclusivity is checked each cycle.
module tb_sap1_controller;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        run = 1'b0;
    logic [3:0]  opcode = 4'b0000;
    logic [5:0]  t;
    logic [11:0] con;
    logic        hlt;

    sap1_controller dut (
        .clk    (clk),
        .res    (res),
        .run    (run),
        .opcode (opcode),
        .t      (t),
        .con    (con),
        .hlt    (hlt)
    );

    always #5 clk = ~clk;

    localparam logic [11:0] CP = 12'h800, EP = 12'h400, LM = 12'h200, CE = 12'h100;
    localparam logic [11:0] LI = 12'h080, EI = 12'h040, LA = 12'h020, EA = 12'h010;
    localparam logic [11:0] SU = 12'h008, EU = 12'h004, LB = 12'h002, LO = 12'h001;
    localparam logic [11:0] NONE = 12'h000;

    localparam logic [5:0] T1 = 6'b100000, T2 = 6'b010000, T3 = 6'b001000;
    localparam logic [5:0] T4 = 6'b000100, T5 = 6'b000010, T6 = 6'b000001;
    localparam logic [5:0] TH = 6'b000000;

    localparam logic [3:0] LDA = 4'b0000, ADD = 4'b0001, SUB = 4'b0010;
    localparam logic [3:0] UND = 4'b0111, OUT = 4'b1110, HLT = 4'b1111;

    typedef struct packed {
        logic        chk;
        logic [5:0]  t;
        logic [11:0] con;
        logic        hlt;
        logic [7:0]  id;
    } exp_t;

    exp_t expq[$];
    int   asserts  = 0;
    int   failures = 0;
    logic armed    = 1'b0;
    logic [7:0] step_id = 8'd0;

    // Apply inputs for one cycle and queue what the outputs must show during it;
    // the state transition then happens at the next falling edge.
    task automatic step(input logic r, input logic rn, input logic [3:0] op,
                        input logic chk, input logic [5:0] et,
                        input logic [11:0] ec, input logic eh);
        exp_t e;
        @(negedge clk);
        #1;
        res    = r;
        run    = rn;
        opcode = op;
        e.chk  = chk;
        e.t    = et;
        e.con  = ec;
        e.hlt  = eh;
        e.id   = step_id;
        step_id = step_id + 8'd1;
        expq.push_back(e);
    endtask

    task automatic go(input logic [3:0] op, input logic [5:0] et, input logic [11:0] ec);
        step(1'b0, 1'b1, op, 1'b1, et, ec, 1'b0);
    endtask

    task automatic fetch(input logic [3:0] op);
        go(op, T1, EP | LM);
        go(op, T2, CP);
        go(op, T3, CE | LI);
    endtask

    // Monitor: compare queued expectation against outputs on each rising edge
    always @(posedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            if (e.chk) begin
                asserts++;
                if (t !== e.t || con !== e.con || hlt !== e.hlt) begin
                    failures++;
                    $display("FAIL step%0d: got t=%b con=%h hlt=%b, expected t=%b con=%h hlt=%b",
                             e.id, t, con, hlt, e.t, e.con, e.hlt);
                end else begin
                    $display("ok   step%0d: t=%b con=%h hlt=%b", e.id, t, con, hlt);
                end
            end
        end
    end

    // At most one bus driver (ep, ce, ei, ea, eu) asserted in any cycle
    always @(posedge clk) begin
        if (armed) begin
            asserts++;
            if ($countones({con[10], con[8], con[6], con[4], con[2]}) > 1 ||
                $isunknown(con)) begin
                failures++;
                $display("FAIL bus_exclusive: con=%h t=%b, required at most one of ep/ce/ei/ea/eu",
                         con, t);
            end
        end
    end

    initial begin
        // Reset (nothing known yet), then LDA from T1
        step(1'b1, 1'b1, LDA, 1'b0, TH, NONE, 1'b0);
        armed = 1'b1;
        fetch(LDA);
        go(LDA, T4, EI | LM);
        go(LDA, T5, CE | LA);
        go(LDA, T6, NONE);

        // SUB, then wrap into ADD
        fetch(SUB);
        go(SUB, T4, EI | LM);
        go(SUB, T5, CE | LB);
        go(SUB, T6, EU | LA | SU);
        fetch(ADD);
        go(ADD, T4, EI | LM);
        go(ADD, T5, CE | LB);
        go(ADD, T6, EU | LA);

        // Hold at T2 for three edges, then resume with a single cp cycle
        go(LDA, T1, EP | LM);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, LDA, 1'b1, T2, NONE, 1'b0);
        go(LDA, T2, CP);
        go(LDA, T3, CE | LI);
        go(LDA, T4, EI | LM);
        go(LDA, T5, CE | LA);
        go(LDA, T6, NONE);

        // Undefined opcode behaves as NOP, then OUT
        fetch(UND);
        go(UND, T4, NONE);
        go(UND, T5, NONE);
        go(UND, T6, NONE);
        fetch(OUT);
        go(OUT, T4, EA | LO);
        go(OUT, T5, NONE);
        go(OUT, T6, NONE);

        // Reset during T5 of ADD: no T6 controls, back to T1
        fetch(ADD);
        go(ADD, T4, EI | LM);
        step(1'b1, 1'b1, ADD, 1'b1, T5, CE | LB, 1'b0);
        go(ADD, T1, EP | LM);
        go(ADD, T2, CP);

        // Reset with run low: T1 held, control word gated off
        step(1'b1, 1'b0, LDA, 1'b1, T3, NONE, 1'b0);
        step(1'b0, 1'b0, LDA, 1'b1, T1, NONE, 1'b0);
        go(LDA, T1, EP | LM);
        go(LDA, T2, CP);
        go(LDA, T3, CE | LI);
        go(LDA, T4, EI | LM);
        go(LDA, T5, CE | LA);
        go(LDA, T6, NONE);

        // HLT: halted four edges after T1, sticky until reset
        fetch(HLT);
        go(HLT, T4, NONE);
        step(1'b0, 1'b1, HLT, 1'b1, TH, NONE, 1'b1);
        step(1'b0, 1'b1, HLT, 1'b1, TH, NONE, 1'b1);
        step(1'b0, 1'b1, LDA, 1'b1, TH, NONE, 1'b1);
        step(1'b1, 1'b1, LDA, 1'b1, TH, NONE, 1'b1);
        go(LDA, T1, EP | LM);
        go(LDA, T2, CP);

        // Random opcode / run traffic (HLT excluded) for the exclusivity check
        for (int i = 0; i < 120; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 14));
            step(1'b0, ($urandom_range(0, 3) != 0), op, 1'b0, TH, NONE, 1'b0);
        end
        step(1'b1, 1'b1, LDA, 1'b0, TH, NONE, 1'b0);
        go(LDA, T1, EP | LM);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && expq.size() > 0; i++) @(posedge clk);
        #1;
        if (expq.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
